debounce_edge_detector: RTL and testbench
=========================================

Name: debounce_edge_detector

Overview:
- Conditions a raw, asynchronous 1-bit input (switch/button/external line) before it drives the registered D flip-flop stage and downstream logic.
- Synchronises the input with two flops and debounces it with a counter-based FSM.
- Outputs a clean level, one-cycle rise/fall pulses, and a wrapping count of rising edges.

Parameters:
- STABLE_CYCLES, 4, consecutive synchronised samples at the new level needed to accept a transition; legal range 2..255.
- CNT_W, 8, width of edge_count.
- Derived localparam TMR_W = clog2(STABLE_CYCLES+1), width of the internal stability counter.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- d  input  1  raw asynchronous input
- q  output  1  debounced level, registered
- rise  output  1  one-cycle pulse when q goes 0->1
- fall  output  1  one-cycle pulse when q goes 1->0
- edge_count  output  CNT_W  number of accepted rising edges, wraps

Behaviour:
- Single clock domain: clk. Reset: rst is synchronous and active-high, sampled on clk rising edge, and has priority over all other logic.
- Reset values: sync1=0, sync2=0, state=IDLE_LO, timer=0, q=0, rise=0, fall=0, edge_count=0. Asserting rst mid-debounce abandons the pending transition; no pulse is produced.
- Synchroniser: sync1<=d, sync2<=sync1. Only sync2 feeds the FSM; d is never used directly.
- FSM states: IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO.
- IDLE_LO (q=0):
  - if sync2==1 -> WAIT_HI, timer<=1;
  - else stay.
- WAIT_HI (q=0):
  - if sync2==0 -> IDLE_LO, timer<=0 (glitch rejected);
  - else if timer==STABLE_CYCLES-1 -> IDLE_HI, q<=1, rise<=1, edge_count<=edge_count+1, timer<=0;
  - else timer<=timer+1.
- IDLE_HI / WAIT_LO: mirror image of IDLE_LO / WAIT_HI with sync2==0 as the trigger. Acceptance sets q<=0 and fall<=1; edge_count is unchanged.
- rise and fall are registered, high for exactly one cycle, and never high in the same cycle.
- Latency: d is sampled at edge k. sync2 is seen by the FSM at edge k+2, which is the first stable observation. q and its pulse update at edge k+1+STABLE_CYCLES (edge k+5 for the default). The fall path has the same latency.
- A pulse or glitch on sync2 shorter than STABLE_CYCLES consecutive samples produces no change in q, rise, fall or edge_count.
- Re-bounce during WAIT_* restarts the qualification from IDLE_*. The count never carries over.
- edge_count wraps from 2^CNT_W-1 to 0 with no flag.
- A constant input held high through reset deassertion is accepted like any other rise. q goes to 1 at STABLE_CYCLES+1 edges after the first post-reset edge, and rise pulses.

Decomposition:
- Package debounce_pkg: state enum typedef (IDLE_LO, WAIT_HI, IDLE_HI, WAIT_LO, 2-bit encoding), default-parameter constants.
- Sub-module sync_2ff (clk, rst, d -> q, two flops, synchronous active-high reset) instantiated once. The FSM, timer and counter live in the top module.

Test Plan:
- Reset: hold rst=1 for 3 cycles with d toggling -> q=0, rise=0, fall=0, edge_count=0 throughout.
- Clean rise: rst=0, d=0 for 5 cycles, then d=1 held -> q goes 1 exactly 5 edges after d is sampled high; rise high for 1 cycle; edge_count=1.
- Glitch rejection: from q=0, d=1 for 2 cycles then back to 0 -> q stays 0, no rise, edge_count unchanged. Repeat from q=1 with a 3-cycle low glitch -> q stays 1, no fall.
- Bounce then settle: d pattern 1,0,1,1,0,1 then held 1 -> single rise only after 4 consecutive high sync2 samples; edge_count increments by 1.
- Fall and wrap: CNT_W=2, apply 5 clean high/low pulses of 10 cycles each -> 5 rise and 5 fall pulses, never coincident; edge_count sequence 1,2,3,0,1.
- Reset mid-debounce: assert rst during WAIT_HI (timer=2) -> next edge state=IDLE_LO, q=0, no rise; after release with d still 1, rise occurs STABLE_CYCLES+1 edges later.

Source files
------------

// File: rtl/debounce_pkg.sv
`default_nettype none
// ============================================================================
// Module      : debounce_pkg
// Description : State encoding and default parameters for the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package debounce_pkg;

    localparam int DEF_STABLE_CYCLES = 4;
    localparam int DEF_CNT_W         = 8;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        WAIT_HI = 2'd1,
        IDLE_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_e;

endpackage : debounce_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_2ff
// Description : Two-flop synchroniser for a single asynchronous bit.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta_q;
    logic r_sync_q;
    logic w_meta_d;
    logic w_sync_d;

    always_comb begin
        w_meta_d = d;
        w_sync_d = r_meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta_q <= 1'b0;
            r_sync_q <= 1'b0;
        end else begin
            r_meta_q <= w_meta_d;
            r_sync_q <= w_sync_d;
        end
    end

    assign q = r_sync_q;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/debounce_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : debounce_edge_detector
// Description : Synchronises and debounces a raw input; emits a clean level,
//               one-cycle rise/fall pulses and a wrapping rising-edge count.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_edge_detector #(
    parameter int STABLE_CYCLES = debounce_pkg::DEF_STABLE_CYCLES,
    parameter int CNT_W         = debounce_pkg::DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    output logic             q,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] edge_count
);

    import debounce_pkg::*;

    localparam int               TMR_W      = $clog2(STABLE_CYCLES + 1);
    localparam logic [TMR_W-1:0] C_TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] C_TMR_LAST = TMR_W'(STABLE_CYCLES - 1);

    logic             w_sync;

    state_e           r_state_q, w_state_d;
    logic [TMR_W-1:0] r_timer_q, w_timer_d;
    logic             r_q_q,     w_q_d;
    logic             r_rise_q,  w_rise_d;
    logic             r_fall_q,  w_fall_d;
    logic [CNT_W-1:0] r_cnt_q,   w_cnt_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (d),
        .q   (w_sync)
    );

    // The timer counts consecutive samples at the candidate level; any
    // sample back at the current level drops straight to the idle state.
    always_comb begin
        w_state_d = r_state_q;
        w_timer_d = r_timer_q;
        w_q_d     = r_q_q;
        w_rise_d  = 1'b0;
        w_fall_d  = 1'b0;
        w_cnt_d   = r_cnt_q;

        case (r_state_q)
            IDLE_LO: begin
                if (w_sync) begin
                    w_state_d = WAIT_HI;
                    w_timer_d = C_TMR_ONE;
                end
            end
            WAIT_HI: begin
                if (!w_sync) begin
                    w_state_d = IDLE_LO;
                    w_timer_d = '0;
                end else if (r_timer_q == C_TMR_LAST) begin
                    w_state_d = IDLE_HI;
                    w_timer_d = '0;
                    w_q_d     = 1'b1;
                    w_rise_d  = 1'b1;
                    w_cnt_d   = r_cnt_q + CNT_W'(1);
                end else begin
                    w_timer_d = r_timer_q + C_TMR_ONE;
                end
            end
            IDLE_HI: begin
                if (!w_sync) begin
                    w_state_d = WAIT_LO;
                    w_timer_d = C_TMR_ONE;
                end
            end
            WAIT_LO: begin
                if (w_sync) begin
                    w_state_d = IDLE_HI;
                    w_timer_d = '0;
                end else if (r_timer_q == C_TMR_LAST) begin
                    w_state_d = IDLE_LO;
                    w_timer_d = '0;
                    w_q_d     = 1'b0;
                    w_fall_d  = 1'b1;
                end else begin
                    w_timer_d = r_timer_q + C_TMR_ONE;
                end
            end
            default: begin
                w_state_d = IDLE_LO;
                w_timer_d = '0;
                w_q_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= IDLE_LO;
            r_timer_q <= '0;
            r_q_q     <= 1'b0;
            r_rise_q  <= 1'b0;
            r_fall_q  <= 1'b0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_timer_q <= w_timer_d;
            r_q_q     <= w_q_d;
            r_rise_q  <= w_rise_d;
            r_fall_q  <= w_fall_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign q          = r_q_q;
    assign rise       = r_rise_q;
    assign fall       = r_fall_q;
    assign edge_count = r_cnt_q;

endmodule : debounce_edge_detector
`default_nettype wire

// File: tb/tb_debounce_edge_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_debounce_edge_detector
// Description : Directed and random stimulus against a window-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_edge_detector;

    localparam int S = 4;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         d   = 1'b0;
    logic         q;
    logic         rise;
    logic         fall;
    logic [W-1:0] edge_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: history of applied inputs, level, edge of last change/reset.
    bit           d_h[$];
    bit           rst_h[$];
    bit           m_q;
    int           m_last;
    logic [W-1:0] m_cnt;
    bit           m_rise;
    bit           m_fall;

    bit rnd_v;
    int rnd_len;

    debounce_edge_detector #(
        .STABLE_CYCLES (S),
        .CNT_W         (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .d          (d),
        .q          (q),
        .rise       (rise),
        .fall       (fall),
        .edge_count (edge_count)
    );

    always #5 clk = ~clk;

    // Synchronised value observed at edge n: the input applied two edges
    // earlier, or 0 if either of the two preceding edges was a reset.
    function automatic bit samp(int n);
        if (n < 2) return 1'b0;
        if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
        return d_h[n-2];
    endfunction

    // The level flips once S consecutive observations, all taken after the
    // previous flip (or reset), disagree with it.
    task automatic model_edge();
        int n;
        bit all_diff;
        n      = d_h.size() - 1;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (rst_h[n]) begin
            m_q    = 1'b0;
            m_last = n;
            m_cnt  = '0;
        end else if (n - S >= m_last) begin
            all_diff = 1'b1;
            for (int j = 0; j < S; j++)
                if (samp(n - j) == m_q) all_diff = 1'b0;
            if (all_diff) begin
                m_q    = ~m_q;
                m_last = n;
                if (m_q) begin
                    m_rise = 1'b1;
                    m_cnt  = m_cnt + 1'b1;
                end else begin
                    m_fall = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s edge=%0d observed=%0h expected=%0h", tag, d_h.size() - 1, obs, exp);
        end
    endtask

    task automatic step(input bit dv, input bit rv);
        @(negedge clk);
        d   = dv;
        rst = rv;
        @(posedge clk);
        d_h.push_back(dv);
        rst_h.push_back(rv);
        model_edge();
        #1;
        chk("q",          32'(q),          32'(m_q));
        chk("rise",       32'(rise),       32'(m_rise));
        chk("fall",       32'(fall),       32'(m_fall));
        chk("edge_count", 32'(edge_count), 32'(m_cnt));
        chk("no_overlap", 32'(rise & fall), 32'd0);
    endtask

    initial begin
        m_q    = 1'b0;
        m_last = 0;
        m_cnt  = '0;
        m_rise = 1'b0;
        m_fall = 1'b0;

        // Reset held with the input toggling
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        chk("reset_q",   32'(q),          32'd0);
        chk("reset_cnt", 32'(edge_count), 32'd0);

        repeat (5) step(1'b0, 1'b0);

        // Short high glitch is rejected
        repeat (2) step(1'b1, 1'b0);
        repeat (8) step(1'b0, 1'b0);
        chk("glitch_hi_q", 32'(q), 32'd0);

        // Clean rise: level changes exactly S+1 edges after first high sample
        step(1'b1, 1'b0);
        for (int i = 0; i < S; i++) begin
            step(1'b1, 1'b0);
            chk("lat_pre_q", 32'(q), 32'd0);
        end
        step(1'b1, 1'b0);
        chk("lat_q",    32'(q),          32'd1);
        chk("lat_rise", 32'(rise),       32'd1);
        chk("lat_cnt",  32'(edge_count), 32'd1);
        repeat (6) step(1'b1, 1'b0);

        // Short low glitch is rejected
        repeat (3) step(1'b0, 1'b0);
        repeat (8) step(1'b1, 1'b0);
        chk("glitch_lo_q", 32'(q), 32'd1);

        repeat (8) step(1'b0, 1'b0);
        chk("fall_q", 32'(q), 32'd0);

        // Bounce then settle high
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0);
        repeat (8) step(1'b1, 1'b0);
        chk("bounce_cnt", 32'(edge_count), 32'd2);
        repeat (10) step(1'b0, 1'b0);

        // Reset while qualifying a rise, input stays high afterwards
        repeat (4) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        chk("midrst_q",   32'(q),          32'd0);
        chk("midrst_cnt", 32'(edge_count), 32'd0);
        repeat (10) step(1'b1, 1'b0);
        chk("midrst_after_q", 32'(q), 32'd1);
        repeat (8) step(1'b0, 1'b0);

        // Random run lengths straddling the qualification window
        for (int r = 0; r < 400; r++) begin
            rnd_v   = 1'($urandom_range(0, 1));
            rnd_len = $urandom_range(1, 8);
            if ($urandom_range(0, 59) == 0)
                step(rnd_v, 1'b1);
            repeat (rnd_len) step(rnd_v, 1'b0);
        end

        // Enough clean pulses to wrap the counter
        repeat (8) step(1'b0, 1'b0);
        for (int p = 0; p < 260; p++) begin
            repeat (6) step(1'b1, 1'b0);
            repeat (6) step(1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_debounce_edge_detector
`default_nettype wire
